// File: rtl/elixirchip_es1_ram_stream_reader.sv
// Read-side controller for the ES1 simple-dual-port RAM: walks an address range and
// presents the registered read data as a valid/ready stream with a last flag.
`timescale 1ns/1ps
module elixirchip_es1_ram_stream_reader #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 18,
  parameter int LEN_BITS   = ADDR_BITS + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  start_addr,
  input  logic [LEN_BITS-1:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_regcke,
  output logic [ADDR_BITS-1:0]  ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam logic [LEN_BITS-1:0]  MAX_LEN  = LEN_BITS'(2 ** ADDR_BITS);
  localparam logic [LEN_BITS-1:0]  LEN_ONE  = LEN_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_BITS-1:0]  addr_cnt;
  logic [LEN_BITS-1:0]   remain;
  logic                  zero_done;
  logic                  vld_p1, last_p1;
  logic                  vld_p2, last_p2;
  logic                  cke, issue, start_cmd, drain_done;

  // A range longer than the address space would re-read words, so saturate it.
  function automatic logic [LEN_BITS-1:0] clamp_len(input logic [LEN_BITS-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  assign cke        = !vld_p2 || m_ready;
  assign issue      = (state == RUN) && cke;
  assign start_cmd  = (state == IDLE) && start;
  assign drain_done = (state == DRAIN) && !vld_p1 && !vld_p2;

  assign ram_en     = issue;
  assign ram_regcke = cke;
  assign ram_addr   = addr_cnt;
  assign m_data     = ram_dout;
  assign m_valid    = vld_p2;
  assign m_last     = last_p2;
  assign done       = zero_done || drain_done;
  assign busy       = (state == RUN) || ((state == DRAIN) && (vld_p1 || vld_p2));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && (length != '0)) state_nxt = RUN;
      RUN:     if (issue && (remain == LEN_ONE)) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      remain    <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      zero_done <= start_cmd && (length == '0);
      if (start_cmd) begin
        addr_cnt <= start_addr;
        remain   <= clamp_len(length);
      end else if (issue) begin
        addr_cnt <= addr_cnt + ADDR_ONE;
        remain   <= remain - LEN_ONE;
      end
    end
  end

  // Stage p1 tracks the RAM address latch, stage p2 the RAM output register;
  // both freeze together with the RAM whenever cke is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (cke) begin
      vld_p1  <= issue;
      last_p1 <= issue && (remain == LEN_ONE);
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

endmodule
